// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU engine: accepts an op over valid/ready, walks a 1-bit slice
// LSB-first for WIDTH cycles, then resolves overflow/SLT and returns the result.
module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             oflo
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic [2:0]       op_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             msb_cin_r;
  logic             msb_cout_r;
  logic             msb_sum_r;

  logic             a_bit_s;
  logic             bb_s;
  logic             sum_s;
  logic             cout_s;
  logic             slice_s;
  logic             ovf_s;
  logic [WIDTH-1:0] fin_result_s;
  logic             fin_oflo_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // One-bit ALU slice on the current operand LSBs
  always_comb begin
    a_bit_s = a_sr_r[0];
    bb_s    = b_sr_r[0] ^ op_r[2];
    sum_s   = a_bit_s ^ bb_s ^ carry_r;
    cout_s  = maj3(a_bit_s, bb_s, carry_r);
    case (op_r)
      3'b000:                 slice_s = a_bit_s & bb_s;
      3'b001:                 slice_s = a_bit_s | bb_s;
      3'b010, 3'b110, 3'b111: slice_s = sum_s;
      default:                slice_s = 1'b0;
    endcase
  end

  // Final result/overflow resolution from the captured MSB step
  always_comb begin
    ovf_s        = msb_cin_r ^ msb_cout_r;
    fin_result_s = '0;
    fin_oflo_s   = 1'b0;
    case (op_r)
      3'b000, 3'b001: begin
        fin_result_s = res_sr_r;
        fin_oflo_s   = 1'b0;
      end
      3'b010, 3'b110: begin
        fin_result_s = res_sr_r;
        fin_oflo_s   = ovf_s;
      end
      3'b111: begin
        // sign of the difference corrected by overflow gives a true signed compare
        fin_result_s[0] = msb_sum_r ^ ovf_s;
        fin_oflo_s      = ovf_s;
      end
      default: begin
        fin_result_s = '0;
        fin_oflo_s   = 1'b0;
      end
    endcase
  end

  // Control FSM, serial datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      result     <= '0;
      zero       <= 1'b0;
      oflo       <= 1'b0;
      a_sr_r     <= '0;
      b_sr_r     <= '0;
      res_sr_r   <= '0;
      op_r       <= 3'b000;
      cnt_r      <= '0;
      carry_r    <= 1'b0;
      msb_cin_r  <= 1'b0;
      msb_cout_r <= 1'b0;
      msb_sum_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            op_r     <= op;
            carry_r  <= op[2];
            cnt_r    <= '0;
            in_ready <= 1'b0;
            state_r  <= SHIFT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_sr_r <= {slice_s, res_sr_r[WIDTH-1:1]};
          carry_r  <= cout_s;
          if (cnt_r == CW'(WIDTH - 1)) begin
            msb_cin_r  <= carry_r;
            msb_cout_r <= cout_s;
            msb_sum_r  <= sum_s;
            state_r    <= FINISH;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        FINISH: begin
          result    <= fin_result_s;
          zero      <= (fin_result_s == '0);
          oflo      <= fin_oflo_s;
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed ops with literal expectations
// plus a cycle-level reference model compared on every falling edge.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         oflo;

  int n_checks = 0;
  int n_fail   = 0;

  alu_serial_ctrl #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .oflo(oflo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {result, zero, oflo}
  function automatic logic [W+1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W-1:0] r;
    logic [W-1:0] s;
    logic [W-1:0] d;
    logic         v;
    logic         sub_v;
    s = x + y;
    d = x - y;
    sub_v = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
    case (o)
      3'b000: begin r = x & y; v = 1'b0; end
      3'b001: begin r = x | y; v = 1'b0; end
      3'b010: begin r = s; v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]); end
      3'b110: begin r = d; v = sub_v; end
      3'b111: begin r = ($signed(x) < $signed(y)) ? W'(1) : W'(0); v = sub_v; end
      default: begin r = '0; v = 1'b0; end
    endcase
    return {r, (r == '0), v};
  endfunction

  // Transaction-level timing model: busy from acceptance, result after WIDTH+1 edges
  logic         m_busy, m_ov, m_zero, m_oflo, p_zero, p_oflo;
  logic [W-1:0] m_res, p_res;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_cnt <= 0;
      m_res <= '0; m_zero <= 1'b0; m_oflo <= 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        {p_res, p_zero, p_oflo} <= model(op, a, b);
      end
    end else if (!m_ov) begin
      if (m_cnt == W) begin
        m_ov <= 1'b1; m_res <= p_res; m_zero <= p_zero; m_oflo <= p_oflo;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (out_ready) begin
      m_ov <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("mdl_out_valid", 32'(out_valid), 32'(m_ov));
      check("mdl_in_ready", 32'(in_ready), 32'(!m_busy));
      check("mdl_result", 32'(result), 32'(m_res));
      check("mdl_zero", 32'(zero), 32'(m_zero));
      check("mdl_oflo", 32'(oflo), 32'(m_oflo));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ez, input logic eo, input int hold);
    int k;
    op = o; a = x; b = y; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin step(); k++; end
    check("accept_timeout", 32'(k < 20), 32'(1));
    step();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    k = 0;
    while (!out_valid && k < 40) begin step(); k++; end
    check("latency", 32'(k), 32'(W + 1));
    check("lit_result", 32'(result), 32'(er));
    check("lit_zero", 32'(zero), 32'(ez));
    check("lit_oflo", 32'(oflo), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid; op = 3'b010; a = W'(1); b = W'(1);
      step();
      check("bp_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_result", 32'(result), 32'(er));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("drop_valid", 32'(out_valid), 32'(0));
    check("ready_back", 32'(in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 3'b000; a = '0; b = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_zero", 32'(zero), 32'(0));
    check("rst_oflo", 32'(oflo), 32'(0));

    run_op(3'b010, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 0);
    run_op(3'b110, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op(3'b110, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 0);
    run_op(3'b111, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0, 0);
    run_op(3'b111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 0);
    run_op(3'b111, 8'h7F, 8'h80, 8'h00, 1'b1, 1'b1, 0);
    run_op(3'b000, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 0);
    run_op(3'b001, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 0);
    run_op(3'b011, 8'hC3, 8'h5A, 8'h00, 1'b1, 1'b0, 0);
    run_op(3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 5);
    run_op(3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 0);

    // Abort an ADD partway through the shift phase
    op = 3'b010; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_result", 32'(result), 32'(0));
    step();
    rst_n = 1'b1;
    step();
    run_op(3'b010, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 0);

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
